// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and default parameters for the FIFO write arbiter
package fifo_arb_pkg;
    typedef enum logic {IDLE, BURST} state_t;
    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping past N-1 to 0
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;
    // descending scan so the nearest candidate to ptr is assigned last
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = W'((int'(ptr) + i) % N);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter steering requester beats into one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic                             fifo_full,
    output logic                             fifo_write_en,
    output logic [DATA_W-1:0]                fifo_write_data,
    output logic                             grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t            state, state_nx;
    logic [ID_W-1:0]   owner, owner_nx, rr_ptr, rr_ptr_nx, pick_idx, owner_inc;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nx;
    logic              pick_found, in_burst;

    rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign in_burst        = state == BURST;
    assign owner_inc       = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
    assign req_ready       = (in_burst && !fifo_full) ? NUM_REQ'(1) << owner : '0;
    assign fifo_write_en   = req_valid[owner] & req_ready[owner];
    assign fifo_write_data = req_data[owner];
    assign grant_valid     = in_burst;
    assign grant_id        = in_burst ? owner : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

    // a burst ends on its MAX_BURST-th beat or as soon as the owner goes idle
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        if (!in_burst) begin
            if (!fifo_full && pick_found) begin
                state_nx    = BURST;
                owner_nx    = pick_idx;
                beat_cnt_nx = '0;
            end
        end else begin
            beat_cnt_nx = beat_cnt + CNT_W'(fifo_write_en);
            if (!req_valid[owner] || beat_cnt_nx == CNT_W'(MAX_BURST)) begin
                state_nx  = IDLE;
                rr_ptr_nx = owner_inc;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: cycle vectors with a write-data scoreboard for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct {
        logic [N-1:0]  valid;
        logic          full;
        logic          we;
        logic [DW-1:0] data;
        logic          gv;
        logic [1:0]    gid;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0][DW-1:0] req_data;
    logic [N-1:0]         req_ready;
    logic                 fifo_full = 1'b0;
    logic                 fifo_write_en;
    logic [DW-1:0]        fifo_write_data;
    logic                 grant_valid;
    logic [1:0]           grant_id;

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] seq [N];
    logic [N-1:0]  acc = '0;
    logic [DW-1:0] sb [$];
    vec_t          vecs [$];

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_full       (fifo_full),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    // requester i streams 0x(i+1)0, 0x(i+1)1, ... advancing only on accepted beats
    always_comb
        for (int i = 0; i < N; i++) req_data[i] = DW'(16 * (i + 1)) + seq[i];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] v, input logic f, input logic we, input logic [DW-1:0] d,
                       input logic gv, input logic [1:0] gid);
        vec_t r;
        r = '{v, f, we, d, gv, gid};
        vecs.push_back(r);
    endtask

    task automatic advance();
        for (int i = 0; i < N; i++) if (acc[i]) seq[i] = seq[i] + 1'b1;
        acc = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        #1;
        check("rst_we", fifo_write_en, 0);
        check("rst_gv", grant_valid, 0);
        check("rst_gid", grant_id, 0);
        check("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = '0;
        acc = '0;
        sb.delete();
    endtask

    task automatic run_vecs(input string tag);
        logic [N-1:0] exp_ready;
        foreach (vecs[k]) begin
            @(negedge clk);
            advance();
            req_valid = vecs[k].valid;
            fifo_full = vecs[k].full;
            if (vecs[k].we) sb.push_back(vecs[k].data);
            #1;
            exp_ready = (vecs[k].gv && !vecs[k].full) ? N'(1) << vecs[k].gid : '0;
            check($sformatf("%s[%0d]_we", tag, k), fifo_write_en, vecs[k].we);
            check($sformatf("%s[%0d]_gv", tag, k), grant_valid, vecs[k].gv);
            check($sformatf("%s[%0d]_gid", tag, k), grant_id, vecs[k].gid);
            check($sformatf("%s[%0d]_ready", tag, k), req_ready, exp_ready);
            if (fifo_write_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s[%0d]_data actual=%0h required=none", tag, k, fifo_write_data);
                end else begin
                    check($sformatf("%s[%0d]_data", tag, k), fifo_write_data, sb.pop_front());
                end
            end
            acc = req_valid & req_ready;
        end
        vecs.delete();
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = '0;

        // single requester, six beats split 4 + 2
        do_reset();
        add(4'b0001, 0, 0, 8'h00, 0, 0);
        for (int b = 0; b < 4; b++) add(4'b0001, 0, 1, 8'h10 + 8'(b), 1, 0);
        add(4'b0001, 0, 0, 8'h00, 0, 0);
        add(4'b0001, 0, 1, 8'h14, 1, 0);
        add(4'b0001, 0, 1, 8'h15, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 0, 0);
        run_vecs("single");

        // all requesters valid: 0,1,2,3,0 with one idle cycle between bursts
        do_reset();
        for (int g = 0; g < 4; g++) begin
            add(4'b1111, 0, 0, 8'h00, 0, 0);
            for (int b = 0; b < 4; b++) add(4'b1111, 0, 1, 8'(16 * (g + 1) + b), 1, 2'(g));
        end
        add(4'b1111, 0, 0, 8'h00, 0, 0);
        add(4'b1111, 0, 1, 8'h14, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 0, 0);
        run_vecs("rr");

        // full stalls the burst after beat 2 for three cycles
        do_reset();
        add(4'b0001, 0, 0, 8'h00, 0, 0);
        add(4'b0001, 0, 1, 8'h10, 1, 0);
        add(4'b0001, 0, 1, 8'h11, 1, 0);
        for (int s = 0; s < 3; s++) add(4'b0001, 1, 0, 8'h00, 1, 0);
        add(4'b0001, 0, 1, 8'h12, 1, 0);
        add(4'b0001, 0, 1, 8'h13, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 0, 0);
        run_vecs("stall");

        // owner drops after one beat, requester 2 takes over
        do_reset();
        add(4'b0101, 0, 0, 8'h00, 0, 0);
        add(4'b0101, 0, 1, 8'h10, 1, 0);
        add(4'b0100, 0, 0, 8'h00, 1, 0);
        add(4'b0100, 0, 0, 8'h00, 0, 0);
        add(4'b0100, 0, 1, 8'h30, 1, 2);
        add(4'b0000, 0, 0, 8'h00, 1, 2);
        add(4'b0000, 0, 0, 8'h00, 0, 0);
        run_vecs("drop");

        // full in idle blocks any grant
        do_reset();
        for (int s = 0; s < 3; s++) add(4'b1111, 1, 0, 8'h00, 0, 0);
        add(4'b1111, 0, 0, 8'h00, 0, 0);
        add(4'b1111, 0, 1, 8'h10, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 0, 0);
        run_vecs("idlefull");

        // asynchronous reset during beat 3 of a requester-1 burst
        do_reset();
        add(4'b0010, 0, 0, 8'h00, 0, 0);
        add(4'b0010, 0, 1, 8'h20, 1, 1);
        add(4'b0010, 0, 1, 8'h21, 1, 1);
        run_vecs("pre_arst");
        @(negedge clk);
        advance();
        req_valid = 4'b0010;
        #1;
        check("arst_beat3_we", fifo_write_en, 1);
        check("arst_beat3_data", fifo_write_data, 8'h22);
        #1;
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("arst_we", fifo_write_en, 0);
        check("arst_gv", grant_valid, 0);
        check("arst_gid", grant_id, 0);
        check("arst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = '0;
        acc = '0;
        add(4'b1111, 0, 0, 8'h00, 0, 0);
        add(4'b1111, 0, 1, 8'h10, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 1, 0);
        add(4'b0000, 0, 0, 8'h00, 0, 0);
        run_vecs("post_arst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
